fifo_sched: RTL and testbench

Scheduler wrapped around the team's 8-deep × 8-bit `fifo`. It shares the FIFO write port between two requesters using round-robin arbitration. It drains the FIFO toward a single consumer in bursts, and it flushes partial bursts after an idle timeout. It sits between packet sources and a downstream serializer that prefers bursty delivery.

---
 rtl/fifo_sched_pkg.sv | 14 +
 rtl/fifo.sv | 51 +++++
 rtl/fifo_sched.sv | 115 +++++++++++
 tb/tb_fifo_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared constants for the burst scheduler and its FIFO.
package fifo_sched_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    // Read FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

endpackage

// File: rtl/fifo.sv
// 8-deep x 8-bit FIFO with registered read data; data_out updates only on rd_en.
module fifo
    import fifo_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Storage array write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_sched.sv
// Round-robin write arbiter plus burst/timeout read scheduler around the 8x8 fifo.
module fifo_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  words
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  remaining;
    logic [7:0]        idle_cnt;
    logic              last_grant;
    logic              grant1;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] data_out;

    fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (wr_data),
        .data_out (data_out),
        .count    (words),
        .full     (full)
    );

    // Winner selection: sole requester wins, contention goes to the one not granted last
    always_comb begin
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
        req0_ready = !full && req0_valid && !grant1;
        req1_ready = !full && req1_valid && grant1;
        wr_en      = req0_ready || req1_ready;
        wr_data    = grant1 ? req1_data : req0_data;
    end

    // Remember the last accepted requester for round-robin fairness
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (wr_en) begin
            last_grant <= grant1;
        end
    end

    // Read FSM: full bursts, timeout-driven partial flushes, one word per ISSUE/OUT pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (words >= CNT_W'(BURST_LEN)) begin
                        state     <= ISSUE;
                        remaining <= CNT_W'(BURST_LEN);
                        idle_cnt  <= '0;
                    end else if (words != '0 && idle_cnt == 8'(TIMEOUT)) begin
                        state     <= ISSUE;
                        remaining <= words;
                        idle_cnt  <= '0;
                    end else if (words == '0) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != 8'(TIMEOUT)) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    state <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        remaining <= remaining - CNT_W'(1);
                        state     <= (remaining == CNT_W'(1)) ? IDLE : ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Consumer-side outputs decoded from the FSM state
    always_comb begin
        rd_en   = (state == ISSUE);
        m_valid = (state == OUT);
        m_data  = m_valid ? data_out : '0;
        m_last  = m_valid && (remaining == CNT_W'(1));
    end

endmodule

// File: tb/tb_fifo_sched.sv
// Directed, table-driven bench for fifo_sched.
module tb_fifo_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       m_valid, m_last, m_ready;
    logic [7:0] m_data;
    logic [3:0] words;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       mr;
        logic       r0;
        logic       r1;
        logic       mv;
        logic [7:0] md;
        logic       ml;
        logic [3:0] w;
    } vec_t;

    vec_t tbl [14];
    logic [7:0] sb [$];

    fifo_sched #(.BURST_LEN(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .words      (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, out_idx, n_in, n_out, coinc, mv_seen, exp_w;
        logic prev_mv, prev_wr, first, rise;
        logic [3:0] prev_words;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; m_ready = 1'b0;

        //            v0    d0     v1    d1     mr    r0    r1    mv    md     ml    w
        tbl[0]  = '{1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd3};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 4'd3};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b0, 4'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 4'd1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b1, 4'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};

        // Reset state
        do_reset();
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_words", int'(words), 0);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);

        // Round-robin fill followed by one full burst
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
            m_ready    = tbl[i].mr;
            #1;
            chk($sformatf("rr%0d_req0_ready", i), int'(req0_ready), int'(tbl[i].r0));
            chk($sformatf("rr%0d_req1_ready", i), int'(req1_ready), int'(tbl[i].r1));
            chk($sformatf("rr%0d_m_valid", i), int'(m_valid), int'(tbl[i].mv));
            chk($sformatf("rr%0d_m_data", i), int'(m_data), int'(tbl[i].md));
            chk($sformatf("rr%0d_m_last", i), int'(m_last), int'(tbl[i].ml));
            chk($sformatf("rr%0d_words", i), int'(words), int'(tbl[i].w));
        end

        // Timeout flush of a 2-word partial burst
        do_reset();
        m_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h11;
        #1 chk("to_req0_ready", int'(req0_ready), 1);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req0_valid = (c == 1); req0_data = 8'h22;
            #1;
            if (m_valid) begin
                n = c;
                break;
            end
        end
        req0_valid = 1'b0;
        chk("to_start_cycle", n, 18);
        chk("to_word0", int'(m_data), 8'h11);
        chk("to_last0", int'(m_last), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("to_word1", int'(m_data), 8'h22);
        chk("to_last1", int'(m_last), 1);
        @(negedge clk);
        #1;
        chk("to_words_after", int'(words), 0);
        chk("to_valid_after", int'(m_valid), 0);

        // Fill to full under backpressure, then drain
        do_reset();
        sb.delete();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_data = 8'hC0 + 8'(n);
            #1;
            if (!req0_ready) break;
            sb.push_back(req0_data);
            n++;
        end
        chk("full_accepted", n, 9);
        chk("full_words", int'(words), 8);
        req1_valid = 1'b1; req1_data = 8'hD1; req0_data = 8'hD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("full_req0_ready", int'(req0_ready), 0);
            chk("full_req1_ready", int'(req1_ready), 0);
            chk("full_hold_words", int'(words), 8);
            chk("full_hold_data", int'(m_data), int'(sb[0]));
            chk("full_hold_last", int'(m_last), 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("full_hs_valid", int'(m_valid), 1);
        chk("full_hs_data", int'(m_data), int'(sb.pop_front()));
        chk("full_hs_req1_ready", int'(req1_ready), 0);
        @(negedge clk);
        #1;
        chk("full_issue_req1_ready", int'(req1_ready), 0);
        chk("full_issue_words", int'(words), 8);
        @(negedge clk);
        #1;
        chk("resume_req1_ready", int'(req1_ready), 1);
        chk("resume_req0_ready", int'(req0_ready), 0);
        chk("resume_words", int'(words), 7);
        chk("resume_data", int'(m_data), int'(sb.pop_front()));
        sb.push_back(8'hD1);
        out_idx = 2;
        for (int c = 0; c < 300 && sb.size() > 0; c++) begin
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            if (m_valid) begin
                chk("drain_data", int'(m_data), int'(sb.pop_front()));
                chk("drain_last", int'(m_last), int'(out_idx == 3 || out_idx == 7 || out_idx == 9));
                out_idx++;
            end
        end
        chk("drain_count", out_idx, 10);
        @(negedge clk);
        #1 chk("drain_words", int'(words), 0);

        // Continuous writes during bursts
        do_reset();
        sb.delete();
        m_ready = 1'b1;
        n_in = 0; n_out = 0; coinc = 0; first = 1'b1;
        prev_mv = 1'b0; prev_wr = 1'b0; prev_words = '0;
        for (int c = 0; c < 400 && n_out < 12; c++) begin
            @(negedge clk);
            req0_valid = (n_in < 12); req0_data = 8'hE0 + 8'(n_in);
            #1;
            rise = m_valid && !prev_mv;
            if (!first) begin
                exp_w = int'(prev_words) + int'(prev_wr) - int'(rise);
                chk("cc_words", int'(words), exp_w);
                if (prev_wr && rise) coinc++;
            end
            first = 1'b0;
            prev_wr = req0_valid && req0_ready;
            if (prev_wr) begin
                sb.push_back(req0_data);
                n_in++;
            end
            if (m_valid) begin
                if (sb.size() == 0) chk("cc_unexpected_word", int'(m_data), -1);
                else chk("cc_data", int'(m_data), int'(sb.pop_front()));
                n_out++;
            end
            prev_mv = m_valid;
            prev_words = words;
        end
        req0_valid = 1'b0;
        chk("cc_out_count", n_out, 12);
        chk("cc_coincidence_seen", int'(coinc > 0), 1);
        chk("cc_leftover", sb.size(), 0);

        // Reset in the middle of a stalled burst
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_data = 8'hF0 + 8'(i);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (m_valid) break;
        end
        chk("mid_valid", int'(m_valid), 1);
        chk("mid_data", int'(m_data), 8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_words", int'(words), 0);
        chk("mid_rst_data", int'(m_data), 0);
        chk("mid_rst_last", int'(m_last), 0);
        mv_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (m_valid) mv_seen++;
        end
        chk("mid_no_resume", mv_seen, 0);
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h5A; m_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (m_valid) break;
        end
        chk("mid_after_valid", int'(m_valid), 1);
        chk("mid_after_data", int'(m_data), 8'h5A);
        chk("mid_after_last", int'(m_last), 1);
        @(negedge clk);
        #1 chk("mid_after_words", int'(words), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
